// File: rtl/carrier_generator_nphase.sv
// Multi-channel triangular carrier generator with programmable peak and per-channel start phase.
// Period changes are taken only as channel 0 leaves its valley, so a carrier ramp is never cut short.
module carrier_generator_nphase #(
    parameter int Width    = 7,
    parameter int Channels = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           en_i,
    input  logic [Width-1:0]               period_i,
    input  logic [Channels*(Width+1)-1:0]  phase_i,
    output logic [Channels*Width-1:0]      count_o,
    output logic [Channels-1:0]            peak_o,
    output logic [Channels-1:0]            valley_o,
    output logic                           trigger_o,
    output logic                           running_o
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e                              state_r;
    state_e                              state_next_s;
    logic [Width-1:0]                    pa_r;
    logic [Width-1:0]                    pa_next_s;
    logic [Width-1:0]                    period_sat_s;
    logic                                pa_load_s;
    logic [Channels-1:0][Width-1:0]      count_r;
    logic [Channels-1:0]                 dir_down_r;
    logic [Channels-1:0][Width:0]        ch_next_s;
    logic [Channels-1:0]                 peak_next_s;
    logic [Channels-1:0]                 valley_next_s;
    logic [Channels-1:0]                 peak_r;
    logic [Channels-1:0]                 valley_r;
    logic                                trigger_r;

    // Start position -> {direction_down, count}; positions past one full period fold to 0.
    function automatic logic [Width:0] phase_load(input logic [Width:0] pos, input logic [Width-1:0] pa);
        logic [Width:0] two_pa;
        logic [Width:0] pos_eff;
        logic [Width:0] mirror;
        two_pa  = {pa, 1'b0};
        pos_eff = (pos >= two_pa) ? {(Width+1){1'b0}} : pos;
        mirror  = two_pa - pos_eff;
        if (pos_eff <= {1'b0, pa}) begin
            phase_load = {1'b0, pos_eff[Width-1:0]};
        end else begin
            phase_load = {1'b1, mirror[Width-1:0]};
        end
    endfunction

    // One triangle step; direction comes from the current count so an overshoot walks back down.
    function automatic logic [Width:0] carrier_step(input logic dir_down, input logic [Width-1:0] cnt,
                                                    input logic [Width-1:0] pa);
        if (!dir_down) begin
            if (cnt < pa) begin
                carrier_step = {1'b0, cnt + Width'(1'b1)};
            end else begin
                carrier_step = {1'b1, cnt - Width'(1'b1)};
            end
        end else begin
            if (cnt > {Width{1'b0}}) begin
                carrier_step = {1'b1, cnt - Width'(1'b1)};
            end else begin
                carrier_step = {1'b0, cnt + Width'(1'b1)};
            end
        end
    endfunction

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: enable alone selects RUN or IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = en_i ? RUN : IDLE;
            RUN:     state_next_s = en_i ? RUN : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next carrier values and flags, computed from the period that will be active after the edge.
    always_comb begin
        ch_next_s     = {(Channels*(Width+1)){1'b0}};
        peak_next_s   = {Channels{1'b0}};
        valley_next_s = {Channels{1'b0}};
        period_sat_s  = (period_i == {Width{1'b0}}) ? Width'(1'b1) : period_i;
        pa_load_s     = (state_r != RUN) || !en_i ||
                        ((count_r[0] == {Width{1'b0}}) && dir_down_r[0]);
        pa_next_s     = pa_load_s ? period_sat_s : pa_r;
        for (int k = 0; k < Channels; k++) begin
            if (state_next_s != RUN) begin
                ch_next_s[k] = {(Width+1){1'b0}};
            end else if (state_r != RUN) begin
                ch_next_s[k] = phase_load(phase_i[k*(Width+1) +: (Width+1)], pa_next_s);
            end else begin
                ch_next_s[k] = carrier_step(dir_down_r[k], count_r[k], pa_next_s);
            end
            peak_next_s[k]   = (state_next_s == RUN) && (ch_next_s[k][Width-1:0] == pa_next_s);
            valley_next_s[k] = (state_next_s == RUN) && (ch_next_s[k][Width-1:0] == {Width{1'b0}});
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pa_r       <= Width'(1'b1);
            count_r    <= {(Channels*Width){1'b0}};
            dir_down_r <= {Channels{1'b0}};
            peak_r     <= {Channels{1'b0}};
            valley_r   <= {Channels{1'b0}};
            trigger_r  <= 1'b0;
        end else begin
            pa_r <= pa_next_s;
            for (int k = 0; k < Channels; k++) begin
                count_r[k]    <= ch_next_s[k][Width-1:0];
                dir_down_r[k] <= ch_next_s[k][Width];
            end
            peak_r    <= peak_next_s;
            valley_r  <= valley_next_s;
            trigger_r <= peak_next_s[0] | valley_next_s[0];
        end
    end

    assign count_o   = count_r;
    assign peak_o    = peak_r;
    assign valley_o  = valley_r;
    assign trigger_o = trigger_r;
    assign running_o = (state_r == RUN);

endmodule
